// File: rtl/wb_stage_p.sv
// Write-back stage: selects ALU or extended load data, masks x0 writes, counts retirements.
// Latency: 1 cycle from accept to registered write port.
// Backpressure: ready_o = ~stall_i; outputs hold on stall, flush inserts a bubble.
module wb_stage_p #(
  parameter  int DATA_W = 32,
  parameter  int AREG_W = 5,
  parameter  int CNT_W  = 32,
  localparam int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              memtoreg_i,
  input  logic              regwrite_i,
  input  logic [1:0]        load_size_i,
  input  logic              load_unsigned_i,
  input  logic [OFF_W-1:0]  byte_off_i,
  input  logic [AREG_W-1:0] write_addr_i,
  input  logic [DATA_W-1:0] write_data_i,
  input  logic [DATA_W-1:0] read_data_i,
  output logic              regwrite_o,
  output logic [AREG_W-1:0] write_addr_o,
  output logic [DATA_W-1:0] write_data_o,
  output logic [CNT_W-1:0]  retire_cnt_o
);

  localparam logic [DATA_W-1:0] ONES = '1;

  logic              accept;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ext_mask;
  logic              sign_bit;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] sel_data;
  logic              wr_en;

  assign ready_o = ~stall_i;
  assign accept  = valid_i & ~stall_i & ~flush_i;

  // Bits above the top of the word shift in as zero, so misaligned
  // sub-word loads simply see zeros in their upper bytes.
  assign shifted = read_data_i >> {byte_off_i, 3'b000};

  // Mask of the bits kept for the selected load size; sizes wider than the
  // datapath collapse to the full word.
  always_comb begin
    ext_mask = ONES;
    unique case (load_size_i)
      2'b00:   ext_mask = ONES >> (DATA_W - 8);
      2'b01:   ext_mask = ONES >> (DATA_W - 16);
      2'b10:   ext_mask = ONES >> (DATA_W - 32);
      default: ext_mask = ONES;
    endcase
  end

  // The sign bit is the highest bit inside the mask; pick it out with a
  // one-hot mask rather than a variable index.
  assign sign_bit = |(shifted & (ext_mask & ~(ext_mask >> 1)));
  assign load_ext = (shifted & ext_mask) |
                    ((~load_unsigned_i & sign_bit) ? ~ext_mask : '0);

  // Writes to x0 or non-writing instructions capture zero data.
  assign wr_en    = regwrite_i & (write_addr_i != '0);
  assign sel_data = wr_en ? (memtoreg_i ? load_ext : write_data_i) : '0;

  // Write-port register: flush beats stall, stall holds, otherwise capture or bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_o   <= 1'b0;
      write_addr_o <= '0;
      write_data_o <= '0;
    end else if (flush_i) begin
      regwrite_o   <= 1'b0;
      write_addr_o <= '0;
      write_data_o <= '0;
    end else if (stall_i) begin
      regwrite_o   <= regwrite_o;
      write_addr_o <= write_addr_o;
      write_data_o <= write_data_o;
    end else if (valid_i) begin
      regwrite_o   <= wr_en;
      write_addr_o <= write_addr_i;
      write_data_o <= sel_data;
    end else begin
      regwrite_o   <= 1'b0;
      write_addr_o <= '0;
      write_data_o <= '0;
    end
  end

  // Retire counter advances on every accepted instruction and wraps freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt_o <= '0;
    end else if (accept) begin
      retire_cnt_o <= retire_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_stage_p.sv
module tb_wb_stage_p;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, stall_i, flush_i, memtoreg_i, regwrite_i, load_unsigned_i;
  logic [1:0]  load_size_i;
  logic [1:0]  byte_off_i;
  logic [4:0]  write_addr_i;
  logic [31:0] write_data_i, read_data_i;

  logic        ready, regwrite;
  logic [4:0]  waddr;
  logic [31:0] wdata, cnt;
  logic        ready4, regwrite4;
  logic [4:0]  waddr4;
  logic [31:0] wdata4;
  logic [3:0]  cnt4;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  wb_stage_p dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready),
    .stall_i(stall_i), .flush_i(flush_i), .memtoreg_i(memtoreg_i),
    .regwrite_i(regwrite_i), .load_size_i(load_size_i),
    .load_unsigned_i(load_unsigned_i), .byte_off_i(byte_off_i),
    .write_addr_i(write_addr_i), .write_data_i(write_data_i),
    .read_data_i(read_data_i), .regwrite_o(regwrite),
    .write_addr_o(waddr), .write_data_o(wdata), .retire_cnt_o(cnt)
  );

  wb_stage_p #(.CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready4),
    .stall_i(stall_i), .flush_i(flush_i), .memtoreg_i(memtoreg_i),
    .regwrite_i(regwrite_i), .load_size_i(load_size_i),
    .load_unsigned_i(load_unsigned_i), .byte_off_i(byte_off_i),
    .write_addr_i(write_addr_i), .write_data_i(write_data_i),
    .read_data_i(read_data_i), .regwrite_o(regwrite4),
    .write_addr_o(waddr4), .write_data_o(wdata4), .retire_cnt_o(cnt4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Both instances see the same stimulus, so their write ports must agree.
  task automatic chk_out(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".we"}, regwrite, we);
    chk({tag, ".addr"}, waddr, a);
    chk({tag, ".data"}, wdata, d);
    chk({tag, ".we4"}, regwrite4, we);
    chk({tag, ".data4"}, wdata4, d);
    chk({tag, ".addr4"}, waddr4, a);
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, ".cnt"}, cnt, exp_cnt);
    chk({tag, ".cnt4"}, cnt4, exp_cnt % 16);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic m, input logic rw, input logic [1:0] sz,
                       input logic u, input logic [1:0] off, input logic [4:0] a,
                       input logic [31:0] wd, input logic [31:0] rd);
    valid_i = v; memtoreg_i = m; regwrite_i = rw; load_size_i = sz;
    load_unsigned_i = u; byte_off_i = off; write_addr_i = a;
    write_data_i = wd; read_data_i = rd;
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 2'd0, 5'd0, 32'h0, 32'h0);
    step; step;
    chk_out("reset", 1'b0, 5'd0, 32'h0);
    chk_cnt("reset");
    chk("reset.ready", ready, 1'b1);
    rst = 1'b0;

    // ALU write
    drive(1, 0, 1, 2'b10, 0, 2'd0, 5'd5, 32'h12345678, 32'h0);
    step; exp_cnt++;
    chk_out("alu", 1'b1, 5'd5, 32'h12345678);
    chk_cnt("alu");

    // Load extension from 0x80FF7F01
    drive(1, 1, 1, 2'b00, 0, 2'd2, 5'd7, 32'h0, 32'h80FF7F01);
    step; exp_cnt++;
    chk_out("lb_off2", 1'b1, 5'd7, 32'hFFFFFFFF);
    drive(1, 1, 1, 2'b00, 0, 2'd3, 5'd7, 32'h0, 32'h80FF7F01);
    step; exp_cnt++;
    chk_out("lb_off3", 1'b1, 5'd7, 32'hFFFFFF80);
    drive(1, 1, 1, 2'b01, 1, 2'd2, 5'd7, 32'h0, 32'h80FF7F01);
    step; exp_cnt++;
    chk_out("lhu_off2", 1'b1, 5'd7, 32'h000080FF);
    drive(1, 1, 1, 2'b10, 0, 2'd0, 5'd7, 32'h0, 32'h80FF7F01);
    step; exp_cnt++;
    chk_out("lw", 1'b1, 5'd7, 32'h80FF7F01);
    drive(1, 1, 1, 2'b11, 0, 2'd0, 5'd8, 32'h0, 32'h80FF7F01);
    step; exp_cnt++;
    chk_out("ld_as_lw", 1'b1, 5'd8, 32'h80FF7F01);
    drive(1, 1, 1, 2'b00, 1, 2'd1, 5'd9, 32'h0, 32'h80FF7F01);
    step; exp_cnt++;
    chk_out("lbu_off1", 1'b1, 5'd9, 32'h0000007F);
    // Misaligned half at offset 3: upper byte reads as zero, sign bit is 0
    drive(1, 1, 1, 2'b01, 0, 2'd3, 5'd9, 32'h0, 32'h80FF7F01);
    step; exp_cnt++;
    chk_out("lh_off3", 1'b1, 5'd9, 32'h00000080);
    chk_cnt("loads");

    // x0 suppression
    drive(1, 0, 1, 2'b10, 0, 2'd0, 5'd0, 32'hDEADBEEF, 32'h0);
    step; exp_cnt++;
    chk_out("x0", 1'b0, 5'd0, 32'h0);
    chk_cnt("x0");
    // regwrite=0 keeps the address but zeroes data
    drive(1, 0, 0, 2'b10, 0, 2'd0, 5'd6, 32'hCAFEF00D, 32'h0);
    step; exp_cnt++;
    chk_out("nowr", 1'b0, 5'd6, 32'h0);
    chk_cnt("nowr");

    // Stall sequence: A accepted, B held off for 3 cycles
    drive(1, 0, 1, 2'b10, 0, 2'd0, 5'd3, 32'hAAAA0001, 32'h0);
    step; exp_cnt++;
    chk_out("A", 1'b1, 5'd3, 32'hAAAA0001);
    drive(1, 0, 1, 2'b10, 0, 2'd0, 5'd4, 32'hBBBB0002, 32'h0);
    stall_i = 1'b1;
    #1 chk("stall.ready", ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step;
      chk_out("stall_hold", 1'b1, 5'd3, 32'hAAAA0001);
      chk("stall.ready_in", ready, 1'b0);
      chk_cnt("stall");
    end
    stall_i = 1'b0;
    step; exp_cnt++;
    chk_out("B", 1'b1, 5'd4, 32'hBBBB0002);
    chk_cnt("B");

    // Flush with valid: dropped and not counted
    flush_i = 1'b1;
    drive(1, 0, 1, 2'b10, 0, 2'd0, 5'd10, 32'h11110000, 32'h0);
    step;
    chk_out("flush", 1'b0, 5'd0, 32'h0);
    chk_cnt("flush");
    flush_i = 1'b0;

    // Flush during stall discards the held instruction
    step; exp_cnt++;
    chk_out("C", 1'b1, 5'd10, 32'h11110000);
    stall_i = 1'b1; flush_i = 1'b1;
    step;
    chk_out("flush_stall", 1'b0, 5'd0, 32'h0);
    chk_cnt("flush_stall");
    stall_i = 1'b0; flush_i = 1'b0;

    // Idle cycle is a bubble
    valid_i = 1'b0;
    step;
    chk_out("idle", 1'b0, 5'd0, 32'h0);
    chk_cnt("idle");

    // Asynchronous reset mid-stream
    drive(1, 0, 1, 2'b10, 0, 2'd0, 5'd12, 32'h0BADF00D, 32'h0);
    step; exp_cnt++;
    chk_out("D", 1'b1, 5'd12, 32'h0BADF00D);
    #2 rst = 1'b1;
    #1;
    exp_cnt = 0;
    chk_out("async_rst", 1'b0, 5'd0, 32'h0);
    chk_cnt("async_rst");
    #1 rst = 1'b0;
    step; exp_cnt++;
    chk_out("post_rst", 1'b1, 5'd12, 32'h0BADF00D);
    chk_cnt("post_rst");

    // Wrap: 17 accepts since reset
    for (int i = 0; i < 16; i++) begin
      step; exp_cnt++;
    end
    chk("wrap.cnt4", cnt4, 4'd1);
    chk("wrap.cnt", cnt, 32'd17);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage_p.md
# wb_stage_p

Parametrised, registered write-back stage of the in-order pipeline, placed between the memory stage and the register file. It selects ALU result or load data, sign/zero-extends sub-word loads using the byte offset, suppresses writes to x0, and presents one registered write port that also feeds the forwarding unit. It adds a valid/ready handshake with stall and flush, and counts retired instructions.

## Interface
- DATA_W, 32: datapath width, 32 or 64.
- AREG_W, 5: register address width.
- CNT_W, 32: retire counter width.
- OFF_W, $clog2(DATA_W/8): byte-offset width, derived, not overridden.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_i  in  1  memory stage presents an instruction.
- ready_o  out  1  stage accepts this cycle; equals ~stall_i, combinational.
- stall_i  in  1  register-file port busy; hold outputs.
- flush_i  in  1  kill incoming instruction.
- memtoreg_i  in  1  1 = load data, 0 = ALU result.
- regwrite_i  in  1  instruction writes a register.
- load_size_i  in  2  00 byte, 01 half, 10 word, 11 double.
- load_unsigned_i  in  1  1 = zero-extend, 0 = sign-extend.
- byte_off_i  in  OFF_W  load byte offset within the word.
- write_addr_i  in  AREG_W  destination register.
- write_data_i  in  DATA_W  ALU result.
- read_data_i  in  DATA_W  raw memory read word.
- regwrite_o  out  1  registered write enable.
- write_addr_o  out  AREG_W  registered destination.
- write_data_o  out  DATA_W  registered write data.
- retire_cnt_o  out  CNT_W  retired-instruction count.

## Operation
- accept = valid_i & ~stall_i & ~flush_i.
- Load path: shifted = read_data_i >> (8*byte_off_i); extract the low 8/16/32/64 bits per load_size_i, then zero- or sign-extend to DATA_W. For DATA_W=32, size 11 is treated as word. Misaligned offsets are not checked: bits shifted past the top read as 0 before extension.
- Data select: memtoreg_i ? extended load : write_data_i.
- x0 rule: if write_addr_i==0 or regwrite_i==0, the captured regwrite is 0 and the data is 0. The address is captured unchanged.
- Next-state priority:
  - rst: all registers 0.
  - flush_i: bubble, meaning regwrite_o=0, write_addr_o=0, write_data_o=0. Flush overrides stall.
  - stall_i: hold all outputs. A held regwrite_o rewrites the same value, which is harmless.
  - accept: capture the selected values.
  - otherwise: bubble.
- Retire counter: +1 on every accept, including instructions with regwrite_i=0. It wraps modulo 2^CNT_W and holds on stall and flush.

## Timing
- Latency 1 cycle: inputs accepted at edge N appear on outputs after edge N.
- ready_o has no registered path. The upstream stage must keep its inputs stable while ready_o=0.
- Reset is asynchronous. Outputs go to 0 immediately on rst, including retire_cnt_o. The first accept is possible at the first edge after rst deasserts.
- flush_i and valid_i in the same cycle: the instruction is dropped and not counted.
- flush_i during stall_i: the bubble loads and the held instruction is discarded.
- The forwarding unit uses regwrite_o/write_addr_o/write_data_o in the same cycle they are visible. Same-cycle regfile write/read bypass is the regfile's responsibility.

## Test plan
- Reset: assert rst mid-stream with regwrite_o=1 -> all outputs 0 asynchronously and retire_cnt_o=0; the first accept after release gives retire_cnt_o=1.
- ALU write: valid_i=1, memtoreg=0, regwrite=1, addr=5, write_data=0x12345678 -> next cycle regwrite_o=1, write_addr_o=5, write_data_o=0x12345678.
- Load extension: read_data=0x80FF7F01.
  - size=00, off=2, signed -> 0xFFFFFFFF.
  - off=3, signed -> 0xFFFFFF80.
  - size=01, off=2, unsigned -> 0x000080FF.
  - size=10, off=0 -> 0x80FF7F01.
- x0 suppression: regwrite=1, addr=0, data=0xDEADBEEF -> regwrite_o=0, write_data_o=0, write_addr_o=0, counter still +1.
- Stall/flush:
  - Accept A.
  - stall_i for 3 cycles with B presented -> outputs hold A, ready_o=0, counter unchanged.
  - Release -> B appears and counter +1.
  - flush_i with valid_i=1 -> bubble, counter unchanged.
- Wrap: CNT_W=4 and 17 accepts -> retire_cnt_o=1.
